pic_move_ctrl: RTL and testbench

Sequencing controller for the picture ROM path in the VGA display. It owns the on-screen origin of the 100×100 RGB565 picture and moves it once per N frames, bouncing off the active-area edges. It generates the per-pixel ROM read enable and the ROM address for the single-port `rom_pic` ROM, which has one cycle of read latency. It also provides a `pic_valid` flag aligned with the ROM data, for the colour mux downstream.

---
 rtl/pic_move_ctrl_if.sv | 26 ++
 rtl/pic_move_ctrl.sv | 150 +++++++++++++++
 tb/tb_pic_move_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_move_ctrl_if.sv
// Pixel-position in / ROM-control out bundle between the VGA timing path and pic_move_ctrl.
// Latency: none, this is wiring only.
// Backpressure: none, the raster is free-running and every signal is sampled once per pixel clock.
interface pic_move_ctrl_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pause;
    logic        rd_en;
    logic [13:0] rom_addr;
    logic        pic_valid;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        frame_end;

    // Raster/control source side (VGA timing generator, testbench).
    modport master (
        output pix_x, pix_y, pause,
        input  rd_en, rom_addr, pic_valid, pos_x, pos_y, frame_end
    );

    // Controller side.
    modport slave (
        input  pix_x, pix_y, pause,
        output rd_en, rom_addr, pic_valid, pos_x, pos_y, frame_end
    );
endinterface

// File: rtl/pic_move_ctrl.sv
// Bouncing-picture controller: owns the picture origin and generates ROM read enable/address per pixel.
// Latency: pixel at t -> rd_en/rom_addr at t+1, pic_valid (aligned with ROM q) at t+2; origin moves 2 cycles after frame_end.
// Backpressure: none, the raster cannot stall; pause only suppresses motion at an update request.
module pic_move_ctrl #(
    parameter int H_VALID   = 640,
    parameter int V_VALID   = 480,
    parameter int H_PIC     = 100,
    parameter int W_PIC     = 100,
    parameter int PIC_SIZE  = 10000,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 2
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    pic_move_ctrl_if.slave bus
);

    typedef enum logic {ST_WAIT, ST_UPDATE} state_t;

    localparam logic [9:0]  POS_X_RST = 10'((H_VALID - H_PIC) / 2);
    localparam logic [9:0]  POS_Y_RST = 10'((V_VALID - W_PIC) / 2);
    localparam logic [9:0]  POS_X_MAX = 10'(H_VALID - H_PIC);
    localparam logic [9:0]  POS_Y_MAX = 10'(V_VALID - W_PIC);
    localparam logic [9:0]  STEP10    = 10'(STEP);
    localparam logic [10:0] STEP11    = 11'(STEP);
    localparam logic [10:0] H_PIC11   = 11'(H_PIC);
    localparam logic [10:0] W_PIC11   = 11'(W_PIC);
    localparam logic [10:0] H_VALID11 = 11'(H_VALID);
    localparam logic [10:0] V_VALID11 = 11'(V_VALID);
    localparam logic [13:0] H_PIC14   = 14'(H_PIC);
    localparam logic [13:0] PIC_SZ14  = 14'(PIC_SIZE);
    localparam logic [7:0]  CNT_LAST  = 8'(FRAME_DIV - 1);

    state_t      state;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        dir_x;      // 1 = moving right
    logic        dir_y;      // 1 = moving down
    logic [7:0]  frame_cnt;
    logic [13:0] line_base;
    logic        rd_en;
    logic [13:0] rom_addr;
    logic        pic_valid;
    logic        frame_end;

    // Everything is compared in 11 bits so pos+size sums cannot wrap; 10'h3FF lands far right of any picture.
    logic [10:0] px11, py11, posx11, posy11;
    logic        in_pic, row_end, last_pix, update_req;
    logic [13:0] col_off, lb_next;

    assign px11   = {1'b0, bus.pix_x};
    assign py11   = {1'b0, bus.pix_y};
    assign posx11 = {1'b0, pos_x};
    assign posy11 = {1'b0, pos_y};

    // Picture window test plus the row-end / last-pixel events derived from it.
    always_comb begin
        in_pic     = (px11 >= posx11) && (px11 < posx11 + H_PIC11) &&
                     (py11 >= posy11) && (py11 < posy11 + W_PIC11);
        row_end    = in_pic && (px11 == posx11 + H_PIC11 - 11'd1);
        last_pix   = (px11 == H_VALID11 - 11'd1) && (py11 == V_VALID11 - 11'd1);
        col_off    = 14'(px11 - posx11);
        lb_next    = line_base + H_PIC14;
        update_req = frame_end && (frame_cnt == CNT_LAST);
    end

    // Address pipeline: running row base instead of a row*width multiply; frame end restarts at word 0.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_en     <= 1'b0;
            rom_addr  <= '0;
            pic_valid <= 1'b0;
            frame_end <= 1'b0;
            line_base <= '0;
        end else begin
            rd_en     <= in_pic;
            pic_valid <= rd_en;
            frame_end <= last_pix;
            if (in_pic)
                rom_addr <= line_base + col_off;
            if (last_pix)
                line_base <= '0;
            else if (row_end)
                line_base <= (lb_next == PIC_SZ14) ? 14'd0 : lb_next;
        end
    end

    // Frame divider and motion FSM; the origin only moves in UPDATE, well before the next active pixel.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_WAIT;
            frame_cnt <= '0;
            pos_x     <= POS_X_RST;
            pos_y     <= POS_Y_RST;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
        end else begin
            if (frame_end)
                frame_cnt <= (frame_cnt == CNT_LAST) ? 8'd0 : frame_cnt + 8'd1;
            case (state)
                ST_WAIT: begin
                    if (update_req && !bus.pause)
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    state <= ST_WAIT;
                    if (dir_x) begin
                        if (posx11 + H_PIC11 + STEP11 <= H_VALID11)
                            pos_x <= pos_x + STEP10;
                        else begin
                            pos_x <= POS_X_MAX;
                            dir_x <= 1'b0;
                        end
                    end else begin
                        if (posx11 >= STEP11)
                            pos_x <= pos_x - STEP10;
                        else begin
                            pos_x <= '0;
                            dir_x <= 1'b1;
                        end
                    end
                    if (dir_y) begin
                        if (posy11 + W_PIC11 + STEP11 <= V_VALID11)
                            pos_y <= pos_y + STEP10;
                        else begin
                            pos_y <= POS_Y_MAX;
                            dir_y <= 1'b0;
                        end
                    end else begin
                        if (posy11 >= STEP11)
                            pos_y <= pos_y - STEP10;
                        else begin
                            pos_y <= '0;
                            dir_y <= 1'b1;
                        end
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.rom_addr  = rom_addr;
    assign bus.pic_valid = pic_valid;
    assign bus.pos_x     = pos_x;
    assign bus.pos_y     = pos_y;
    assign bus.frame_end = frame_end;

endmodule

// File: tb/tb_pic_move_ctrl.sv
// Self-checking bench for pic_move_ctrl: hand table, raster scans against a scoreboard, motion/pause/bounce sequences.
// Latency: expectations are queued when a pixel is driven and compared one clock later.
// Backpressure: none.
module tb_pic_move_ctrl;

    localparam int H_VALID   = 640;
    localparam int V_VALID   = 480;
    localparam int H_PIC     = 100;
    localparam int W_PIC     = 100;
    localparam int PIC_SIZE  = 10000;
    localparam int STEP      = 1;
    localparam int FRAME_DIV = 2;

    logic vga_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    pic_move_ctrl_if pic_if();

    pic_move_ctrl #(
        .H_VALID(H_VALID), .V_VALID(V_VALID), .H_PIC(H_PIC), .W_PIC(W_PIC),
        .PIC_SIZE(PIC_SIZE), .STEP(STEP), .FRAME_DIV(FRAME_DIV)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (pic_if)
    );

    typedef struct {
        logic        rd;
        logic [13:0] addr;
        logic        pv;
        logic        fe;
    } exp_t;

    typedef struct {
        int          x;
        int          y;
        logic        rd;
        logic [13:0] addr;
        logic        pv;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pv_count;

    // Reference model state
    int          m_px, m_py, m_cnt, m_upd;
    bit          m_dx, m_dy;
    logic [13:0] m_addr;
    logic        m_prev_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_px = (H_VALID - H_PIC) / 2;
        m_py = (V_VALID - W_PIC) / 2;
        m_dx = 1'b1;
        m_dy = 1'b1;
        m_cnt = 0;
        m_upd = 0;
        m_addr = '0;
        m_prev_in = 1'b0;
        sb.delete();
    endtask

    task automatic model_move();
        m_upd++;
        if (m_dx) begin
            if (m_px + H_PIC + STEP <= H_VALID) m_px += STEP;
            else begin m_px = H_VALID - H_PIC; m_dx = 1'b0; end
        end else begin
            if (m_px >= STEP) m_px -= STEP;
            else begin m_px = 0; m_dx = 1'b1; end
        end
        if (m_dy) begin
            if (m_py + W_PIC + STEP <= V_VALID) m_py += STEP;
            else begin m_py = V_VALID - W_PIC; m_dy = 1'b0; end
        end else begin
            if (m_py >= STEP) m_py -= STEP;
            else begin m_py = 0; m_dy = 1'b1; end
        end
    endtask

    // Drive one pixel, queue its expected outputs, compare them one clock later.
    task automatic step(input int x, input int y);
        exp_t e, g;
        bit   inp;
        pic_if.pix_x = 10'(x);
        pic_if.pix_y = 10'(y);
        inp = (x >= m_px) && (x < m_px + H_PIC) && (y >= m_py) && (y < m_py + W_PIC);
        if (inp) m_addr = 14'((y - m_py) * H_PIC + (x - m_px));
        e.rd   = inp;
        e.addr = m_addr;
        e.pv   = m_prev_in;
        e.fe   = (x == H_VALID - 1) && (y == V_VALID - 1);
        m_prev_in = inp;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        g = sb.pop_front();
        check("rd_en",     pic_if.rd_en,     g.rd);
        check("rom_addr",  pic_if.rom_addr,  g.addr);
        check("pic_valid", pic_if.pic_valid, g.pv);
        check("frame_end", pic_if.frame_end, g.fe);
        if (pic_if.pic_valid === 1'b1) pv_count++;
    endtask

    // Abbreviated frame: only the last active pixel, then blanking long enough for the origin to settle.
    task automatic short_frame();
        step(H_VALID - 1, V_VALID - 1);
        repeat (3) step(1023, 1023);
        if (m_cnt == FRAME_DIV - 1) begin
            m_cnt = 0;
            if (!pic_if.pause) model_move();
        end else begin
            m_cnt++;
        end
        check("pos_x", pic_if.pos_x, m_px);
        check("pos_y", pic_if.pos_y, m_py);
    endtask

    // Raster over a window enclosing the picture at its reset origin; optionally stop at (300,200).
    task automatic scan(input bit partial);
        pv_count = 0;
        for (int y = 188; y <= 291; y++) begin
            for (int x = 265; x <= 375; x++) begin
                step(x, y);
                if (partial && x == 300 && y == 200) return;
                if (x == 270 && y == 190) check("addr_270_190", pic_if.rom_addr, 0);
                if (x == 369 && y == 190) check("addr_369_190", pic_if.rom_addr, 99);
                if (x == 270 && y == 191) check("addr_270_191", pic_if.rom_addr, 100);
                if (x == 369 && y == 289) check("addr_369_289", pic_if.rom_addr, 9999);
            end
        end
        repeat (2) step(1023, 1023);
        check("pic_valid_count", pv_count, 10000);
    endtask

    task automatic reset_checks();
        check("rst_rd_en",     pic_if.rd_en,     0);
        check("rst_rom_addr",  pic_if.rom_addr,  0);
        check("rst_pic_valid", pic_if.pic_valid, 0);
        check("rst_frame_end", pic_if.frame_end, 0);
        check("rst_pos_x",     pic_if.pos_x,     270);
        check("rst_pos_y",     pic_if.pos_y,     190);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge vga_clk);
        #1;
        reset_checks();
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        vec_t tbl[8];
        int   last_upd;

        tbl[0] = '{270,  190,  1'b1, 14'd0,   1'b0};
        tbl[1] = '{369,  190,  1'b1, 14'd99,  1'b1};
        tbl[2] = '{370,  190,  1'b0, 14'd99,  1'b1};
        tbl[3] = '{270,  191,  1'b1, 14'd100, 1'b0};
        tbl[4] = '{300,  191,  1'b1, 14'd130, 1'b1};
        tbl[5] = '{1023, 1023, 1'b0, 14'd130, 1'b1};
        tbl[6] = '{269,  191,  1'b0, 14'd130, 1'b0};
        tbl[7] = '{369,  191,  1'b1, 14'd199, 1'b0};

        pic_if.pix_x = 10'h3FF;
        pic_if.pix_y = 10'h3FF;
        pic_if.pause = 1'b0;
        pv_count = 0;

        // Power-on reset
        repeat (3) @(posedge vga_clk);
        #1;
        do_reset();

        // Hand-derived vectors: latency, row-end base advance, hold when outside the picture
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].x, tbl[i].y);
            check("tbl_rd_en",     pic_if.rd_en,     tbl[i].rd);
            check("tbl_rom_addr",  pic_if.rom_addr,  tbl[i].addr);
            check("tbl_pic_valid", pic_if.pic_valid, tbl[i].pv);
        end

        // First frame, then motion rate
        do_reset();
        scan(1'b0);
        short_frame();
        short_frame();
        check("rate2_pos_x", pic_if.pos_x, 271);
        check("rate2_pos_y", pic_if.pos_y, 191);
        short_frame();
        short_frame();
        check("rate4_pos_x", pic_if.pos_x, 272);
        check("rate4_pos_y", pic_if.pos_y, 192);

        // Pause: requests dropped while the divider keeps wrapping
        do_reset();
        pic_if.pause = 1'b1;
        repeat (6) short_frame();
        check("pause_pos_x", pic_if.pos_x, 270);
        check("pause_pos_y", pic_if.pos_y, 190);
        pic_if.pause = 1'b0;
        short_frame();
        check("unpause1_pos_x", pic_if.pos_x, 270);
        short_frame();
        check("unpause2_pos_x", pic_if.pos_x, 271);
        check("unpause2_pos_y", pic_if.pos_y, 191);

        // Mid-frame reset, then a clean frame
        do_reset();
        scan(1'b1);
        do_reset();
        scan(1'b0);

        // Bounce off right and top edges
        do_reset();
        last_upd = 0;
        while (m_upd < 573) begin
            short_frame();
            if (m_upd != last_upd) begin
                last_upd = m_upd;
                if (m_upd == 270) check("bounce_x_reach", pic_if.pos_x, 540);
                if (m_upd == 271) check("bounce_x_hold",  pic_if.pos_x, 540);
                if (m_upd == 272) check("bounce_x_back",  pic_if.pos_x, 539);
                if (m_upd == 571) check("bounce_y_reach", pic_if.pos_y, 0);
                if (m_upd == 572) check("bounce_y_hold",  pic_if.pos_y, 0);
                if (m_upd == 573) check("bounce_y_back",  pic_if.pos_y, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
